// File: rtl/breg_write_scheduler.sv
// Write-port owner for the 32x32 register bank: zero-fill sweep after reset,
// then round-robin arbitration between the ALU and load writeback requesters.
module breg_write_scheduler #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NREG       = 32,
    parameter bit          PROTECT_R0 = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] endRD,
    output logic [DATA_W-1:0] dados_Escrita,
    output logic              write,
    output logic              init_done,
    output logic              last_grant,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              ptr;
    logic              run;

    assign run = (state == RUN);

    // ptr names the requester preferred when both are valid
    always_comb begin
        req0_ready = run & req0_valid & (~req1_valid | ~ptr);
        req1_ready = run & req1_valid & (~req0_valid | ptr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= INIT;
            cnt           <= '0;
            ptr           <= 1'b0;
            write         <= 1'b0;
            endRD         <= '0;
            dados_Escrita <= '0;
            init_done     <= 1'b0;
            last_grant    <= 1'b0;
            conflict_cnt  <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    write         <= 1'b1;
                    endRD         <= cnt;
                    dados_Escrita <= '0;
                    cnt           <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (req0_valid && req1_valid && conflict_cnt != 16'hFFFF)
                        conflict_cnt <= conflict_cnt + 16'd1;
                    if (req0_ready) begin
                        endRD         <= req0_addr;
                        dados_Escrita <= req0_data;
                        write         <= !(PROTECT_R0 && req0_addr == '0);
                        last_grant    <= 1'b0;
                        ptr           <= 1'b1;
                    end else if (req1_ready) begin
                        endRD         <= req1_addr;
                        dados_Escrita <= req1_data;
                        write         <= !(PROTECT_R0 && req1_addr == '0);
                        last_grant    <= 1'b1;
                        ptr           <= 1'b0;
                    end else begin
                        write <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_breg_write_scheduler.sv
// Scoreboard bench for breg_write_scheduler: expected bank writes are queued by
// the stimulus and popped by per-instance monitors on every write pulse.
module tb_breg_write_scheduler;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr  = '0;
    logic [DW-1:0] req0_data  = '0;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr  = '0;
    logic [DW-1:0] req1_data  = '0;

    logic          rdy0_a, rdy1_a, w_a, done_a, lg_a;
    logic [AW-1:0] e_a;
    logic [DW-1:0] d_a;
    logic [15:0]   cc_a;
    logic          rdy0_b, rdy1_b, w_b, done_b, lg_b;
    logic [AW-1:0] e_b;
    logic [DW-1:0] d_b;
    logic [15:0]   cc_b;

    always #5 clock = ~clock;

    breg_write_scheduler #(.PROTECT_R0(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(rdy0_a),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(rdy1_a),
        .endRD(e_a), .dados_Escrita(d_a), .write(w_a),
        .init_done(done_a), .last_grant(lg_a), .conflict_cnt(cc_a)
    );

    breg_write_scheduler #(.PROTECT_R0(1'b0)) dut_np (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(rdy0_b),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(rdy1_b),
        .endRD(e_b), .dados_Escrita(d_b), .write(w_b),
        .init_done(done_b), .last_grant(lg_b), .conflict_cnt(cc_b)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];
    wr_t x_a, x_b;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit to_a, input bit to_b);
        wr_t t;
        t.a = a;
        t.d = d;
        if (to_a) q_a.push_back(t);
        if (to_b) q_b.push_back(t);
    endtask

    always @(negedge clock) begin
        if (w_a) begin
            if (q_a.size() == 0) begin
                chk("protected bank write unexpected", {27'd0, e_a, d_a}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                x_a = q_a.pop_front();
                chk("protected bank write", {27'd0, e_a, d_a}, {27'd0, x_a.a, x_a.d});
            end
        end
    end

    always @(negedge clock) begin
        if (w_b) begin
            if (q_b.size() == 0) begin
                chk("open bank write unexpected", {27'd0, e_b, d_b}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                x_b = q_b.pop_front();
                chk("open bank write", {27'd0, e_b, d_b}, {27'd0, x_b.a, x_b.d});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] a0 [3];
    logic [AW-1:0] a1 [2];
    bit            g  [5];
    int            i0, i1;

    initial begin
        a0 = '{5'd1, 5'd2, 5'd6};
        a1 = '{5'd3, 5'd4};
        g  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clock);
        #1;
        chk("reset write", w_a, 0);
        chk("reset endRD", e_a, 0);
        chk("reset data", d_a, 0);
        chk("reset init_done", done_a, 0);
        chk("reset last_grant", lg_a, 0);
        chk("reset conflict_cnt", cc_a, 0);

        // partial sweep up to address 10, then reset
        for (int i = 0; i <= 10; i++) push(AW'(i), '0, 1, 1);
        reset = 1'b0;
        for (int n = 0; n < 100 && q_a.size() != 0; n++) begin
            @(negedge clock);
            #1;
        end
        chk("partial sweep drained", q_a.size(), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid-sweep reset write", w_a, 0);
        chk("mid-sweep reset endRD", e_a, 0);

        // full sweep, with both requesters pending throughout
        for (int i = 0; i < 32; i++) push(AW'(i), '0, 1, 1);
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h1111;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h2222;
        reset = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            #1;
            if (done_a) break;
            chk("ready during init", {rdy0_a, rdy1_a}, 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("init_done after sweep", done_a, 1);
        chk("sweep write count", q_a.size(), 0);
        chk("conflict after init", cc_a, 0);

        // single requester
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        chk("single req0_ready", rdy0_a, 1);
        chk("single req1_ready", rdy1_a, 0);
        push(5'd5, 32'hDEADBEEF, 1, 1);
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        chk("single write", w_a, 1);
        chk("single last_grant", lg_a, 0);
        @(posedge clock);
        #1;
        chk("single write drops", w_a, 0);

        // register 0 protection
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'd7;
        #1;
        chk("r0 req1_ready", rdy1_a, 1);
        push(5'd0, 32'd7, 0, 1);
        @(posedge clock);
        #1;
        req1_valid = 1'b0;
        chk("r0 last_grant", lg_a, 1);
        chk("r0 write suppressed", w_a, 0);
        chk("r0 unprotected write", {w_b, e_b}, {1'b1, 5'd0});

        // contention: grants 0,1,0,1 then req0 alone
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 5; c++) begin
            req0_valid = (i0 < 3);
            req1_valid = (i1 < 2);
            if (i0 < 3) begin
                req0_addr = a0[i0];
                req0_data = 32'hA000_0000 | 32'(a0[i0]);
            end
            if (i1 < 2) begin
                req1_addr = a1[i1];
                req1_data = 32'hB000_0000 | 32'(a1[i1]);
            end
            #1;
            chk("contention readies", {rdy0_a, rdy1_a}, {!g[c], g[c]});
            if (!g[c]) push(req0_addr, req0_data, 1, 1);
            else       push(req1_addr, req1_data, 1, 1);
            @(posedge clock);
            #1;
            if (!g[c]) i0++;
            else       i1++;
            if (c == 3) begin
                chk("contention conflict_cnt", cc_a, 4);
                chk("contention last_grant", lg_a, 1);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("conflict after solo grant", cc_a, 4);

        // saturation: ptr now favours req1
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
        for (int n = 0; n < 70000; n++) begin
            #1;
            chk("alternating readies", {rdy0_a, rdy1_a}, (n % 2 == 0) ? 2'b01 : 2'b10);
            if (n % 2 == 0) push(5'd8, 32'h88, 1, 1);
            else            push(5'd7, 32'h77, 1, 1);
            @(posedge clock);
            #1;
            if (n == 65529) chk("conflict one below max", cc_a, 16'hFFFE);
            if (n == 65530) chk("conflict at max", cc_a, 16'hFFFF);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("conflict saturated", cc_a, 16'hFFFF);
        repeat (3) @(posedge clock);
        #1;
        chk("protected queue drained", q_a.size(), 0);
        chk("open queue drained", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
